// File: rtl/mem_stage.sv
// Memory stage: one instruction in flight, issues a data-memory access when needed, then hands results to writeback.
// Optional alignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  icode_i,
    input  logic [31:0] valE_i,
    input  logic [31:0] valA_i,
    input  logic [7:0]  dstE_i,
    input  logic [7:0]  dstM_i,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  icode_o,
    output logic [31:0] valE_o,
    output logic [31:0] valM_o,
    output logic [7:0]  dstE_o,
    output logic [7:0]  dstM_o,
    output logic [1:0]  stat_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned STAT_W = 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [BYTE_W-1:0] I_CALL   = 8'h8;
    localparam logic [BYTE_W-1:0] I_RET    = 8'h9;
    localparam logic [BYTE_W-1:0] I_RMMOVL = 8'h4;
    localparam logic [BYTE_W-1:0] I_MRMOVL = 8'h5;
    localparam logic [BYTE_W-1:0] I_PUSHL  = 8'hA;
    localparam logic [BYTE_W-1:0] I_POPL   = 8'hB;

    localparam logic [STAT_W-1:0] STAT_AOK = 2'b00;
    localparam logic [STAT_W-1:0] STAT_ADR = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [BYTE_W-1:0] icode_q, icode_d;
    logic [DATA_W-1:0] valE_q, valE_d;
    logic [DATA_W-1:0] valM_q, valM_d;
    logic [BYTE_W-1:0] dstE_q, dstE_d;
    logic [BYTE_W-1:0] dstM_q, dstM_d;
    logic [STAT_W-1:0] stat_q, stat_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;

    logic              accept;
    logic              is_wr_op;
    logic              is_rd_op;
    logic              use_valA_addr;
    logic [DATA_W-1:0] acc_addr;
    logic              misaligned;

    // Decode of the incoming instruction's memory behaviour.
    assign is_wr_op      = (icode_i == I_RMMOVL) || (icode_i == I_PUSHL) || (icode_i == I_CALL);
    assign use_valA_addr = (icode_i == I_POPL) || (icode_i == I_RET);
    assign is_rd_op      = (icode_i == I_MRMOVL) || use_valA_addr;
    assign acc_addr      = use_valA_addr ? valA_i : valE_i;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (is_wr_op || is_rd_op) && (acc_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign in_ready = rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        icode_d = icode_q;
        valE_d  = valE_q;
        valM_d  = valM_q;
        dstE_d  = dstE_q;
        dstM_d  = dstM_q;
        stat_d  = stat_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;

        case (state_q)
            S_IDLE: begin
            end
            S_ACCESS: begin
                if (dmem_ack) begin
                    if (!we_q) begin
                        valM_d = dmem_rdata;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready && !in_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Accept only happens in IDLE or DONE, so it overrides the case above.
        if (accept) begin
            icode_d = icode_i;
            valE_d  = valE_i;
            valM_d  = '0;
            dstE_d  = dstE_i;
            dstM_d  = dstM_i;
            addr_d  = acc_addr;
            wdata_d = valA_i;
            we_d    = is_wr_op;
            stat_d  = misaligned ? STAT_ADR : STAT_AOK;
            state_d = ((is_wr_op || is_rd_op) && !misaligned) ? S_ACCESS : S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            icode_q <= '0;
            valE_q  <= '0;
            valM_q  <= '0;
            dstE_q  <= '0;
            dstM_q  <= '0;
            stat_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            icode_q <= icode_d;
            valE_q  <= valE_d;
            valM_q  <= valM_d;
            dstE_q  <= dstE_d;
            dstM_q  <= dstM_d;
            stat_q  <= stat_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    // Handshake strobes are masked by reset so they drop as soon as reset asserts.
    assign dmem_req   = rst && (state_q == S_ACCESS);
    assign dmem_we    = dmem_req && we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign out_valid  = rst && (state_q == S_DONE);

    assign icode_o = icode_q;
    assign valE_o  = valE_q;
    assign valM_o  = valM_q;
    assign dstE_o  = dstE_q;
    assign dstM_o  = dstM_q;
    assign stat_o  = stat_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, corner sequences, and random traffic against a transaction-level model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [7:0]  icode_i, dstE_i, dstM_i;
    logic [31:0] valE_i, valA_i;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        out_valid, out_ready;
    logic [7:0]  icode_o, dstE_o, dstM_o;
    logic [31:0] valE_o, valM_o;
    logic [1:0]  stat_o;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .icode_i(icode_i), .valE_i(valE_i), .valA_i(valA_i), .dstE_i(dstE_i), .dstM_i(dstM_i),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .icode_o(icode_o), .valE_o(valE_o), .valM_o(valM_o), .dstE_o(dstE_o), .dstM_o(dstM_o),
        .stat_o(stat_o)
    );

    typedef struct {
        logic [7:0]  icode;
        logic [31:0] valE, valA, valM, addr;
        logic [7:0]  dstE, dstM;
        logic [1:0]  stat;
        bit          mem, wr;
    } item_t;

    typedef struct {
        logic [7:0]  icode;
        logic [31:0] valE, valA;
        logic [7:0]  dstE, dstM;
        int          lat;
        logic [31:0] rdata;
        int          hold;
        int          exp_reqs;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_valM;
        logic [1:0]  exp_stat;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Model: at most one instruction held; it is visible once its memory part is finished.
    bit    have = 1'b0;
    item_t cur;

    bit          rand_mode = 1'b0;
    int          dir_lat = 1;
    logic [31:0] dir_rdata = '0;
    logic        dir_spur = 1'b0;
    int          req_run = 0;
    logic [31:0] mem [logic [31:0]];

    int          n_req_cyc = 0;
    int          n_done = 0;
    logic [31:0] last_addr, last_wdata;
    logic        last_we;
    bit          s_ov, s_hs, s_req;
    item_t       got;
    logic [31:0] outs_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic item_t mk_item(input logic [7:0] ic, input logic [31:0] e, input logic [31:0] a,
                                      input logic [7:0] de, input logic [7:0] dm);
        item_t it;
        it.icode = ic; it.valE = e; it.valA = a; it.dstE = de; it.dstM = dm;
        it.valM  = '0; it.stat = 2'b00;
        it.wr    = (ic == 8'h4) || (ic == 8'hA) || (ic == 8'h8);
        it.mem   = it.wr || (ic == 8'h5) || (ic == 8'hB) || (ic == 8'h9);
        it.addr  = ((ic == 8'hB) || (ic == 8'h9)) ? a : e;
`ifdef MEM_ALIGN_CHECK_EN
        if (it.mem && (it.addr[1:0] != 2'b00)) begin
            it.mem  = 1'b0;
            it.stat = 2'b10;
        end
`endif
        return it;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_A5A5);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    // One cycle: respond to memory, check against the model, advance the model, wait for next negedge.
    task automatic step();
        bit want_ir, want_ov, want_req;
        if (rand_mode) begin
            dmem_ack   = dmem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            dmem_rdata = (dmem_req && dmem_ack) ? mem_rd(dmem_addr) : $urandom;
        end else begin
            dmem_ack   = dmem_req ? (req_run == dir_lat - 1) : dir_spur;
            dmem_rdata = dir_rdata;
        end
        #1;
        want_ir  = rst && (!have || (!cur.mem && out_ready));
        want_ov  = rst && have && !cur.mem;
        want_req = rst && have && cur.mem;
        chk("in_ready", 32'(in_ready), 32'(want_ir));
        chk("out_valid", 32'(out_valid), 32'(want_ov));
        chk("dmem_req", 32'(dmem_req), 32'(want_req));
        chk("dmem_we", 32'(dmem_we), 32'(want_req && cur.wr));
        if (want_req) begin
            chk("dmem_addr", dmem_addr, cur.addr);
            if (cur.wr) chk("dmem_wdata", dmem_wdata, cur.valA);
        end
        if (want_ov) begin
            chk("icode_o", 32'(icode_o), 32'(cur.icode));
            chk("valE_o", valE_o, cur.valE);
            chk("valM_o", valM_o, cur.valM);
            chk("dstE_o", 32'(dstE_o), 32'(cur.dstE));
            chk("dstM_o", 32'(dstM_o), 32'(cur.dstM));
            chk("stat_o", 32'(stat_o), 32'(cur.stat));
        end
        s_ov  = out_valid;
        s_req = dmem_req;
        s_hs  = out_valid && out_ready;
        if (s_hs) begin
            outs_q.push_back(valE_o);
            got.icode = icode_o; got.valE = valE_o; got.valM = valM_o;
            got.dstE = dstE_o; got.dstM = dstM_o; got.stat = stat_o;
        end
        if (dmem_req) begin
            n_req_cyc++;
            last_addr = dmem_addr; last_we = dmem_we; last_wdata = dmem_wdata;
            if (dmem_ack && dmem_we) mem[dmem_addr] = dmem_wdata;
        end
        req_run = (dmem_req && !dmem_ack) ? req_run + 1 : 0;
        if (!rst) begin
            have = 1'b0;
        end else begin
            if (want_req && dmem_ack) begin
                cur.mem = 1'b0;
                if (!cur.wr) cur.valM = dmem_rdata;
            end
            if (want_ov && out_ready) begin
                have = 1'b0;
                n_done++;
            end
            if (in_valid && want_ir) begin
                cur  = mk_item(icode_i, valE_i, valA_i, dstE_i, dstM_i);
                have = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int ov_cyc   = 0;
        int first_ov = 0;
        bit done     = 1'b0;
        n_req_cyc = 0; dir_lat = v.lat; dir_rdata = v.rdata; dir_spur = 1'b0;
        in_valid = 1'b1; icode_i = v.icode; valE_i = v.valE; valA_i = v.valA;
        dstE_i = v.dstE; dstM_i = v.dstM; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            out_ready = (ov_cyc >= v.hold);
            step();
            if (s_ov) begin
                if (first_ov == 0) first_ov = c;
                ov_cyc++;
            end
            if (s_hs) done = 1'b1;
        end
        if (!done) chk($sformatf("v%0d timeout", idx), 32'd0, 32'd1);
        chk($sformatf("v%0d req_cycles", idx), 32'(n_req_cyc), 32'(v.exp_reqs));
        if (v.exp_reqs > 0) begin
            chk($sformatf("v%0d addr", idx), last_addr, v.exp_addr);
            chk($sformatf("v%0d we", idx), 32'(last_we), 32'(v.exp_we));
            if (v.exp_we) chk($sformatf("v%0d wdata", idx), last_wdata, v.exp_wdata);
        end
        chk($sformatf("v%0d latency", idx), 32'(first_ov), 32'(v.exp_reqs + 1));
        chk($sformatf("v%0d ov_cycles", idx), 32'(ov_cyc), 32'(v.hold + 1));
        chk($sformatf("v%0d valM", idx), got.valM, v.exp_valM);
        chk($sformatf("v%0d stat", idx), 32'(got.stat), 32'(v.exp_stat));
        chk($sformatf("v%0d valE", idx), got.valE, v.valE);
        chk($sformatf("v%0d icode", idx), 32'(got.icode), 32'(v.icode));
        chk($sformatf("v%0d dstE", idx), 32'(got.dstE), 32'(v.dstE));
        chk($sformatf("v%0d dstM", idx), 32'(got.dstM), 32'(v.dstM));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " icode_o"}, 32'(icode_o), 32'd0);
        chk({tag, " valE_o"}, valE_o, 32'd0);
        chk({tag, " valM_o"}, valM_o, 32'd0);
        chk({tag, " dstE_o"}, 32'(dstE_o), 32'd0);
        chk({tag, " dstM_o"}, 32'(dstM_o), 32'd0);
        chk({tag, " stat_o"}, 32'(stat_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [9];
        logic [31:0] b2b [3];

        //            icode  valE          valA          dstE   dstM   lat rdata         hold reqs addr          we    wdata         valM          stat
        vecs[0] = '{8'h6, 32'd5,        32'd9,        8'd3,  8'hF,  0, 32'd0,        0,   0, 32'd0,        1'b0, 32'd0,        32'd0,        2'b00};
        vecs[1] = '{8'h5, 32'h100,      32'h44,       8'hF,  8'd2,  3, 32'hDEADBEEF, 0,   3, 32'h100,      1'b0, 32'd0,        32'hDEADBEEF, 2'b00};
        vecs[2] = '{8'hA, 32'h1FC,      32'd7,        8'd4,  8'hF,  1, 32'hFFFF0000, 4,   1, 32'h1FC,      1'b1, 32'd7,        32'd0,        2'b00};
        vecs[3] = '{8'hB, 32'h300,      32'h200,      8'd4,  8'd6,  2, 32'h12345678, 0,   2, 32'h200,      1'b0, 32'd0,        32'h12345678, 2'b00};
        vecs[4] = '{8'h9, 32'h44,       32'h40,       8'd4,  8'hF,  1, 32'hCAFE0001, 1,   1, 32'h40,       1'b0, 32'd0,        32'hCAFE0001, 2'b00};
        vecs[5] = '{8'h8, 32'h80,       32'h1234,     8'd4,  8'hF,  2, 32'h0BADF00D, 0,   2, 32'h80,       1'b1, 32'h1234,     32'd0,        2'b00};
`ifdef MEM_ALIGN_CHECK_EN
        vecs[6] = '{8'h4, 32'h102,      32'h55,       8'hF,  8'hF,  1, 32'd0,        0,   0, 32'd0,        1'b0, 32'd0,        32'd0,        2'b10};
`else
        vecs[6] = '{8'h4, 32'h102,      32'h55,       8'hF,  8'hF,  1, 32'd0,        0,   1, 32'h102,      1'b1, 32'h55,       32'd0,        2'b00};
`endif
        vecs[7] = '{8'h1, 32'd0,        32'd0,        8'hF,  8'hF,  0, 32'd0,        2,   0, 32'd0,        1'b0, 32'd0,        32'd0,        2'b00};
        vecs[8] = '{8'h3, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 8'hFF, 0, 32'hFFFFFFFF, 0,   0, 32'd0,        1'b0, 32'd0,        32'd0,        2'b00};

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        icode_i = '0; valE_i = '0; valA_i = '0; dstE_i = '0; dstM_i = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        @(negedge clk);
        step();
        step();
        chk_zero("reset");
        chk("reset dmem_addr", dmem_addr, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Back-to-back register ops with writeback always ready.
        b2b[0] = 32'h11; b2b[1] = 32'h22; b2b[2] = 32'h33;
        outs_q.delete();
        rand_mode = 1'b0; out_ready = 1'b1;
        for (int s = 0; s < 5; s++) begin
            in_valid = (s < 3);
            if (s < 3) begin
                icode_i = 8'h3; valE_i = b2b[s]; dstE_i = 8'(s + 1); dstM_i = 8'hF;
            end
            step();
            chk($sformatf("b2b out_valid s%0d", s), 32'(s_ov), 32'((s >= 1) && (s <= 3)));
        end
        chk("b2b count", 32'(outs_q.size()), 32'd3);
        for (int k = 0; k < 3 && k < outs_q.size(); k++)
            chk($sformatf("b2b valE %0d", k), outs_q[k], b2b[k]);

        // Reset while a read is outstanding, then a late ack.
        dir_lat = 100; dir_spur = 1'b0;
        in_valid = 1'b1; icode_i = 8'hB; valE_i = 32'h999; valA_i = 32'h200;
        dstE_i = 8'd4; dstM_i = 8'd5; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("rstacc req", 32'(s_req), 32'd1);
        chk("rstacc addr", last_addr, 32'h200);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk_zero("rstacc");
        dir_spur = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            chk($sformatf("rstacc no out_valid %0d", s), 32'(s_ov), 32'd0);
        end
        dir_spur = 1'b0;

        // Random traffic against the model.
        rand_mode = 1'b1;
        n_done = 0;
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            icode_i   = 8'($urandom_range(0, 11));
            valE_i    = rand_addr();
            valA_i    = rand_addr();
            dstE_i    = 8'($urandom);
            dstM_i    = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        chk("random progress", 32'(n_done > 300), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port: in_valid  in  1  execute-stage result valid.
REQ-004 SHALL have port: in_ready  out  1  stage can accept a new instruction this cycle.
REQ-005 SHALL have ports: icode_i in 8, valE_i in 32, valA_i in 32, dstE_i in 8, dstM_i in 8  execute results, meanings as in execute stage.
REQ-006 SHALL have ports: dmem_req out 1, dmem_we out 1, dmem_addr out 32, dmem_wdata out 32  data-memory request.
REQ-007 SHALL have ports: dmem_ack in 1, dmem_rdata in 32  data-memory completion; rdata valid with ack.
REQ-008 SHALL have ports: out_valid out 1, out_ready in 1  handshake to writeback.
REQ-009 SHALL have ports: icode_o out 8, valE_o out 32, valM_o out 32, dstE_o out 8, dstM_o out 8, stat_o out 2  writeback payload.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-011 in_ready SHALL be 1 in IDLE, 1 in DONE only when out_ready=1, else 0.
REQ-012 Accept = in_valid & in_ready; on accept SHALL register icode, valE, valA, dstE, dstM.
REQ-013 Memory ops SHALL be: RMMOVL(4), PUSHL(A), CALL(8) write M[valE]=valA; MRMOVL(5) read M[valE]; POPL(B), RET(9) read M[valA].
REQ-014 Accept of memory op SHALL go to ACCESS; accept of any other icode SHALL go to DONE (latency 1 cycle).
REQ-015 In ACCESS, dmem_req=1 and dmem_we/addr/wdata SHALL be held constant until the cycle dmem_ack=1.
REQ-016 On dmem_ack in ACCESS: reads SHALL capture dmem_rdata into valM_o; SHALL go to DONE; dmem_req deasserts next cycle.
REQ-017 dmem_ack outside ACCESS SHALL be ignored.
REQ-018 In DONE, out_valid=1 and all payload outputs SHALL hold until out_ready=1.
REQ-019 DONE with out_ready=1 and in_valid=1 SHALL accept the new instruction same cycle (back-to-back, no bubble); with in_valid=0 SHALL go to IDLE.
REQ-020 valM_o SHALL be 0 for non-read instructions; valE_o, dstE_o, dstM_o, icode_o SHALL equal captured values unmodified.
REQ-021 dmem_we SHALL be 0 whenever dmem_req=0.
REQ-022 Throughput: non-memory ops 1 per cycle; memory ops 1 per (ack latency + 1) cycles.

Reset
REQ-023 rst=0 at a rising edge SHALL force IDLE, all registered outputs 0, stat_o=0.
REQ-024 While rst=0, in_ready, out_valid, dmem_req SHALL be 0.
REQ-025 Reset during ACCESS SHALL abandon the transaction; a later dmem_ack SHALL be ignored.
REQ-026 First cycle after rst returns to 1, in_ready SHALL be 1.

Configuration
REQ-027 Macro MEM_ALIGN_CHECK_EN defined: memory op with address[1:0]!=0 SHALL issue no request, go to DONE next cycle with stat_o=2'b10, valM_o=0; aligned ops stat_o=2'b00.
REQ-028 Macro undefined: no alignment check, unaligned addresses issued unchanged, stat_o SHALL be constant 0; port list identical.

Verification
REQ-029 Reset then OPL(6) valE=5, dstE=3, out_ready=1 -> out_valid next cycle, valE_o=5, dstE_o=3, valM_o=0, no dmem_req.
REQ-030 MRMOVL valE=0x100, ack 3 cycles later with rdata=0xDEADBEEF -> dmem_req held 3 cycles addr 0x100 we=0, then out_valid with valM_o=0xDEADBEEF.
REQ-031 PUSHL valE=0x1FC valA=7, out_ready=0 for 4 cycles -> single write 0x1FC/7, out_valid held 4 cycles, in_ready=0 until out_ready=1.
REQ-032 Three back-to-back IRMOVL with in_valid/out_ready=1 -> three consecutive out_valid cycles, no bubbles, values in order.
REQ-033 POPL valA=0x200, rst=0 while in ACCESS, then ack -> outputs 0, IDLE, ack ignored, no out_valid.
REQ-034 With MEM_ALIGN_CHECK_EN, RMMOVL valE=0x102 -> no dmem_req, out_valid next cycle, stat_o=2'b10.
